ram_error_logger: RTL

//  Consumer of the RAM test controller's error reports. Takes per-lane error strobes plus failing

---
 rtl/ram_error_logger_pkg.sv | 21 ++
 rtl/ram_error_logger_if.sv | 29 ++
 rtl/ram_error_logger_fifo.sv | 57 +++++
 rtl/ram_error_logger.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ram_error_logger_pkg.sv
// Shared types and constants for the RAM error logger slice.
package ram_test_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    // One logged failure: lane in the MSB, failing address below it.
    typedef struct packed {
        logic                      lane;
        logic [ADDR_W_DEFAULT-1:0] addr;
    } log_entry_t;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        LOGGING = 2'd1,
        HALTED  = 2'd2
    } log_state_t;

endpackage

// File: rtl/ram_error_logger_if.sv
// Error-strobe input lanes and show-ahead readout handshake of the logger.
interface ram_error_logger_if
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = ram_test_pkg::ADDR_W_DEFAULT
) ();

    logic              err_valid_a;
    logic [ADDR_W-1:0] err_addr_a;
    logic              err_valid_b;
    logic [ADDR_W-1:0] err_addr_b;
    logic              out_valid;
    logic              out_ready;
    logic              out_lane;
    logic [ADDR_W-1:0] out_addr;

    // Test controller / host reader side.
    modport master (
        output err_valid_a, err_addr_a, err_valid_b, err_addr_b, out_ready,
        input  out_valid, out_lane, out_addr
    );

    // Logger side.
    modport slave (
        input  err_valid_a, err_addr_a, err_valid_b, err_addr_b, out_ready,
        output out_valid, out_lane, out_addr
    );

endinterface

// File: rtl/ram_error_logger_fifo.sv
// error_log_fifo: dual-write (0/1/2 pushes per cycle), single show-ahead read.
// Pointers carry one extra wrap bit so occupancy is a plain subtraction.
module error_log_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic [1:0]    push_cnt,
    input  logic [W-1:0]  push0,
    input  logic [W-1:0]  push1,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [PW-1:0] occupancy
);

    localparam int AW = PW - 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr1_s;

    assign wr_ptr1_s = wr_ptr_r + PW'(1'b1);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign occupancy = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update; second push lands one slot behind the first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_cnt != 2'd0) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push0;
            end
            if (push_cnt == 2'd2) begin
                mem_r[wr_ptr1_s[AW-1:0]] <= push1;
            end
            wr_ptr_r <= wr_ptr_r + PW'(push_cnt);
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
        end
    end

endmodule

// File: rtl/ram_error_logger.sv
// ram_error_logger: counts RAM test failures, latches the first one and queues
// all of them for a host reader. Optional: RAM_ERR_DEDUP_EN suppresses repeated
// {lane,addr} entries per lane (still counted as failures, never as drops).
module ram_error_logger
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = ram_test_pkg::ADDR_W_DEFAULT,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    ram_error_logger_if.slave     bus,
    output logic [CNT_W-1:0]      fail_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  first_valid,
    output logic                  first_lane,
    output logic [ADDR_W-1:0]     first_addr
);

    localparam int PW = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    log_state_t       state_r;
    logic [PW-1:0]    occupancy_s;
    logic [PW-1:0]    free_s;
    logic             empty_s;
    logic [ADDR_W:0]  head_s;
    logic             hit_a_s;
    logic             hit_b_s;
    logic             live_a_s;
    logic             live_b_s;
    logic [1:0]       push_cnt_s;
    logic [ADDR_W:0]  push0_s;
    logic [ADDR_W:0]  push1_s;
    logic [1:0]       drop_inc_s;
    logic [1:0]       fail_inc_s;

    assign free_s     = PW'(DEPTH) - occupancy_s;
    assign fail_inc_s = {1'b0, bus.err_valid_a} + {1'b0, bus.err_valid_b};

`ifdef RAM_ERR_DEDUP_EN
    logic              last_a_valid_r;
    logic [ADDR_W-1:0] last_a_addr_r;
    logic              last_b_valid_r;
    logic [ADDR_W-1:0] last_b_addr_r;
    logic              wr_a_s;
    logic              wr_b_s;

    assign hit_a_s = bus.err_valid_a && last_a_valid_r && (last_a_addr_r == bus.err_addr_a);
    assign hit_b_s = bus.err_valid_b && last_b_valid_r && (last_b_addr_r == bus.err_addr_b);
    assign wr_a_s  = live_a_s && (state_r != HALTED) && (free_s >= PW'(2'd1));
    assign wr_b_s  = live_b_s && (state_r != HALTED) &&
                     (live_a_s ? (free_s >= PW'(2'd2)) : (free_s >= PW'(2'd1)));

    // Remember the last address actually written per lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_a_valid_r <= 1'b0;
            last_a_addr_r  <= {ADDR_W{1'b0}};
            last_b_valid_r <= 1'b0;
            last_b_addr_r  <= {ADDR_W{1'b0}};
        end else if (clear) begin
            last_a_valid_r <= 1'b0;
            last_a_addr_r  <= {ADDR_W{1'b0}};
            last_b_valid_r <= 1'b0;
            last_b_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            if (wr_a_s) begin
                last_a_valid_r <= 1'b1;
                last_a_addr_r  <= bus.err_addr_a;
            end
            if (wr_b_s) begin
                last_b_valid_r <= 1'b1;
                last_b_addr_r  <= bus.err_addr_b;
            end
        end
    end
`else
    assign hit_a_s = 1'b0;
    assign hit_b_s = 1'b0;
`endif

    assign live_a_s = bus.err_valid_a && !hit_a_s;
    assign live_b_s = bus.err_valid_b && !hit_b_s;

    // Decide pushes and drops from free space at the start of the cycle (pops not credited).
    always_comb begin
        push_cnt_s = 2'd0;
        push0_s    = {(ADDR_W + 1){1'b0}};
        push1_s    = {(ADDR_W + 1){1'b0}};
        drop_inc_s = 2'd0;
        if (state_r == HALTED) begin
            drop_inc_s = {1'b0, live_a_s} + {1'b0, live_b_s};
        end else if (live_a_s && live_b_s) begin
            if (free_s >= PW'(2'd2)) begin
                push_cnt_s = 2'd2;
                push0_s    = {LANE_A, bus.err_addr_a};
                push1_s    = {LANE_B, bus.err_addr_b};
            end else if (free_s == PW'(2'd1)) begin
                push_cnt_s = 2'd1;
                push0_s    = {LANE_A, bus.err_addr_a};
                drop_inc_s = 2'd1;
            end else begin
                drop_inc_s = 2'd2;
            end
        end else if (live_a_s || live_b_s) begin
            if (free_s >= PW'(2'd1)) begin
                push_cnt_s = 2'd1;
                push0_s    = live_a_s ? {LANE_A, bus.err_addr_a} : {LANE_B, bus.err_addr_b};
            end else begin
                drop_inc_s = 2'd1;
            end
        end else begin
            push_cnt_s = 2'd0;
        end
    end

    // State, saturating counters and first-failure latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ARMED;
            fail_count  <= {CNT_W{1'b0}};
            drop_count  <= {CNT_W{1'b0}};
            first_valid <= 1'b0;
            first_lane  <= 1'b0;
            first_addr  <= {ADDR_W{1'b0}};
        end else if (clear) begin
            state_r     <= ARMED;
            fail_count  <= {CNT_W{1'b0}};
            drop_count  <= {CNT_W{1'b0}};
            first_valid <= 1'b0;
            first_lane  <= 1'b0;
            first_addr  <= {ADDR_W{1'b0}};
        end else begin
            fail_count <= sat_add(fail_count, fail_inc_s);
            drop_count <= sat_add(drop_count, drop_inc_s);
            case (state_r)
                ARMED: begin
                    if (bus.err_valid_a || bus.err_valid_b) begin
                        first_valid <= 1'b1;
                        first_lane  <= bus.err_valid_a ? LANE_A : LANE_B;
                        first_addr  <= bus.err_valid_a ? bus.err_addr_a : bus.err_addr_b;
                        state_r     <= (drop_inc_s != 2'd0) ? HALTED : LOGGING;
                    end
                end
                LOGGING: begin
                    if (drop_inc_s != 2'd0) begin
                        state_r <= HALTED;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                end
                default: begin
                    state_r <= ARMED;
                end
            endcase
        end
    end

    error_log_fifo #(
        .W     (ADDR_W + 1),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push_cnt  (push_cnt_s),
        .push0     (push0_s),
        .push1     (push1_s),
        .pop       (bus.out_valid && bus.out_ready),
        .head      (head_s),
        .empty     (empty_s),
        .occupancy (occupancy_s)
    );

    assign bus.out_valid = !empty_s;
    assign bus.out_lane  = head_s[ADDR_W];
    assign bus.out_addr  = head_s[ADDR_W-1:0];

endmodule
